// File: rtl/card_store.sv
// card_store: prepaid card meter with debounced insertion, BCD debit, and optional recharge (enabled by defining CARD_RECHARGE_EN)
module card_store (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_in,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [7:0]  debit,
`ifdef CARD_RECHARGE_EN
    input  logic        rc_req,
    input  logic [10:0] rc_amt,
`endif
    output logic [10:0] balance,
    output logic        present,
    output logic        ack,
    output logic        nack,
    output logic        empty,
    output logic        busy
);
    typedef enum logic [2:0] {ABSENT, SETTLE, READY, DEBIT, RESP, WAITREL} state_t;
    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [10:0] r_balance;
    logic [7:0]  r_debit;
    logic        r_present;
    logic        r_ack;
    logic        r_nack;
    logic        r_busy;
    logic        w_rc;
    logic        w_ok;
    logic        w_dok;
    logic [10:0] w_res;
    logic [10:0] w_sub;
    logic [4:0]  w_cs;
    logic [4:0]  w_ts;
`ifdef CARD_RECHARGE_EN
    logic        r_op;
    logic [10:0] r_rc;
    logic [4:0]  w_ca;
    logic [4:0]  w_ta;
    logic [3:0]  w_ya;
    logic        w_cc;
    logic        w_tc;
    logic [10:0] w_add;
`endif

    // Digit-wise BCD arithmetic of the latched amount against the current balance
    always_comb begin
        w_cs  = {1'b0, r_balance[3:0]} - {1'b0, r_debit[3:0]};
        w_ts  = {1'b0, r_balance[7:4]} - {1'b0, r_debit[7:4]} - {4'd0, w_cs[4]};
        w_sub = {r_balance[10:8] - {2'd0, w_ts[4]},
                 w_ts[4] ? w_ts[3:0] + 4'd10 : w_ts[3:0],
                 w_cs[4] ? w_cs[3:0] + 4'd10 : w_cs[3:0]};
        w_dok = (r_debit[7:4] <= 4'd9) && (r_debit[3:0] <= 4'd9) && (r_balance >= {3'd0, r_debit});
`ifdef CARD_RECHARGE_EN
        w_ca  = {1'b0, r_balance[3:0]} + {1'b0, r_rc[3:0]};
        w_cc  = w_ca > 5'd9;
        w_ta  = {1'b0, r_balance[7:4]} + {1'b0, r_rc[7:4]} + {4'd0, w_cc};
        w_tc  = w_ta > 5'd9;
        w_ya  = {1'b0, r_balance[10:8]} + {1'b0, r_rc[10:8]} + {3'd0, w_tc};
        w_add = (w_ya > 4'd7) ? 11'h799 :
                {w_ya[2:0], w_tc ? w_ta[3:0] - 4'd10 : w_ta[3:0], w_cc ? w_ca[3:0] - 4'd10 : w_ca[3:0]};
        w_ok  = r_op ? ((r_rc[7:4] <= 4'd9) && (r_rc[3:0] <= 4'd9)) : w_dok;
        w_res = r_op ? w_add : w_sub;
        w_rc  = rc_req;
`else
        w_ok  = w_dok;
        w_res = w_sub;
        w_rc  = 1'b0;
`endif
    end

    // Next state: card removal overrides everything, otherwise the transaction sequence
    always_comb begin
        w_next = r_state;
        if (!card_in)
            w_next = ABSENT;
        else
            case (r_state)
                ABSENT:  w_next = SETTLE;
                SETTLE:  w_next = (r_cnt == 2'd3) ? READY : SETTLE;
                READY:   w_next = (w_rc || wr_req) ? DEBIT : rd_req ? RESP : READY;
                DEBIT:   w_next = RESP;
                RESP:    w_next = WAITREL;
                WAITREL: w_next = (w_rc || rd_req || wr_req) ? WAITREL : READY;
                default: w_next = ABSENT;
            endcase
    end

    // State, settle counter, registered flags and the card balance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ABSENT;
            r_cnt     <= 2'd0;
            r_balance <= 11'h500;
            r_debit   <= 8'h00;
            r_present <= 1'b0;
            r_ack     <= 1'b0;
            r_nack    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef CARD_RECHARGE_EN
            r_op      <= 1'b0;
            r_rc      <= 11'h000;
`endif
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next == SETTLE) ? r_cnt + 2'd1 : 2'd0;
            r_present <= w_next inside {READY, DEBIT, RESP, WAITREL};
            r_busy    <= !(w_next inside {ABSENT, READY});
            r_ack     <= 1'b0;
            r_nack    <= 1'b0;
            if (r_state == READY && w_next == DEBIT) begin
                r_debit <= debit;
`ifdef CARD_RECHARGE_EN
                r_op    <= w_rc;
                r_rc    <= rc_amt;
`endif
            end
            if (r_state == READY && w_next == RESP)
                r_ack <= 1'b1;
            if (r_state == DEBIT && w_next == RESP) begin
                r_ack  <= w_ok;
                r_nack <= !w_ok;
                if (w_ok)
                    r_balance <= w_res;
            end
        end
    end

    assign balance = r_balance;
    assign present = r_present;
    assign ack     = r_ack;
    assign nack    = r_nack;
    assign busy    = r_busy;
    assign empty   = (r_balance == 11'h000);
endmodule

// File: doc/card_store.md
CARD_STORE -- requirements
Module: card_store

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 card_in  input  1  card seated in slot (raw, undebounced).
REQ-004 rd_req  input  1  meter read request, level, held until ack.
REQ-005 wr_req  input  1  meter debit request, level, held until ack or nack; wr_req wins over rd_req when both are sampled high together.
REQ-006 debit  input  8  two-digit BCD debit amount (00-99 cents), sampled when wr_req is accepted.
REQ-007 balance  output  11  BCD balance: [10:8] yuan (0-7), [7:4] tenths, [3:0] cents.
REQ-008 present  output  1  debounced card-present flag.
REQ-009 ack  output  1  one-cycle pulse; read or debit completed.
REQ-010 nack  output  1  one-cycle pulse; debit refused, balance < debit.
REQ-011 empty  output  1  balance == 11'h000.
REQ-012 busy  output  1  high in every state except ABSENT and READY.

Function
REQ-013 States: ABSENT, SETTLE, READY, DEBIT, RESP, WAITREL.
REQ-014 ABSENT -> SETTLE when card_in = 1; SETTLE counts 4 consecutive cycles with card_in = 1, then -> READY. Any card_in = 0 in SETTLE -> ABSENT with counter cleared.
REQ-015 present = 1 only in READY, DEBIT, RESP and WAITREL.
REQ-016 READY: wr_req = 1 -> DEBIT, debit latched; else rd_req = 1 -> RESP.
REQ-017 DEBIT (one cycle): balance compared to latched debit; if balance >= debit, BCD subtract with per-digit borrow (cents, tenths, yuan), result registered on DEBIT exit; else balance unchanged; -> RESP.
REQ-018 RESP (one cycle): ack = 1 for a read or successful debit; nack = 1 for a refused debit; never both; -> WAITREL.
REQ-019 WAITREL: stays until rd_req = 0 and wr_req = 0, then -> READY; each request is served exactly once.
REQ-020 Read latency: ack exactly 1 cycle after rd_req is sampled in READY. Debit latency: ack/nack exactly 2 cycles after wr_req is sampled in READY.
REQ-021 balance is valid and stable in all states; it changes only on the DEBIT exit edge or on recharge.
REQ-022 balance is retained while the card is absent; it is the card's memory.
REQ-023 card_in = 0 in any state other than ABSENT -> ABSENT next cycle; a debit pending in DEBIT is aborted with no balance change; no ack/nack is issued.
REQ-024 Invalid BCD digits (>9) in debit are treated as a refusal (nack), with no change to balance.
REQ-025 debit = 8'h00 is accepted; ack is issued and balance is unchanged.

Reset
REQ-026 On reset: state ABSENT, settle counter 0, balance = 11'h500, present/ack/nack/busy = 0, empty = 0, latched debit 0.
REQ-027 reset asserted mid-transaction aborts it; no ack/nack is issued after release.

Configuration
REQ-028 CARD_RECHARGE_EN defined: adds input rc_req (1) and input rc_amt (11, BCD).
REQ-029 With CARD_RECHARGE_EN, rc_req is sampled only in READY with present = 1 and has priority over wr_req and rd_req.
REQ-030 With CARD_RECHARGE_EN, an accepted recharge performs a BCD add over 2 cycles (same path as DEBIT), then RESP with ack.
REQ-031 With CARD_RECHARGE_EN, the recharge result saturates at 11'h799; invalid rc_amt digits give nack with balance unchanged.
REQ-032 CARD_RECHARGE_EN undefined: no rc ports exist, and the balance can only decrease.

Verification
REQ-033 Reset, card_in = 1 for 4 cycles, rd_req pulse -> present = 1 after 4 cycles; ack 1 cycle after rd_req; balance = 11'h500.
REQ-034 balance 5.00, wr_req with debit = 8'h03 -> ack 2 cycles later; balance = 11'h497 (borrow across two digits).
REQ-035 balance 0.05, debit = 8'h06 -> nack; balance stays 11'h005; then debit 8'h05 -> ack; balance 11'h000; empty = 1.
REQ-036 card_in glitch low at SETTLE cycle 3 -> back to ABSENT, present stays 0; card_in low during DEBIT -> no ack, balance unchanged, state ABSENT.
REQ-037 wr_req and rd_req high together, held 10 cycles -> exactly one ack; the debit is applied once; READY is re-entered only after both requests drop.
REQ-038 With CARD_RECHARGE_EN, balance 7.50 + rc_amt 11'h100 -> ack; balance = 11'h799 (saturated).
